if_fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the MIPS pipeline; the initiator side of the instruction-memory read interface.
- Owns the PC register and drives a word-aligned byte address to the combinational instruction memory.
- Captures the returned word, together with PC+4, into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects and flushes, and keeps a fetched-instruction counter for debug.

---
 rtl/if_fetch_stage_pkg.sv | 11 +
 rtl/if_fetch_stage_if.sv | 15 +
 rtl/if_fetch_stage_if_id_reg.sv | 28 ++
 rtl/if_fetch_stage.sv | 84 ++++++++
 tb/tb_if_fetch_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage and its pipeline registers.
//   INSTR_W     : instruction word width.
//   NOP_INSTR_C : bubble encoding (sll $0,$0,0).
//   RESET_PC_C  : default PC after reset (word-aligned).
//   PC_INC      : byte distance between consecutive instructions.
package if_fetch_stage_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_C = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_C = 32'h0000_0000;
  localparam int unsigned PC_INC = 4;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read bus: the fetch stage drives a byte address and the
// memory returns the addressed word combinationally in the same cycle.
//   imem_addr  : word-aligned byte address (master -> slave).
//   imem_rdata : instruction word for imem_addr (slave -> master).
interface if_fetch_stage_if
  import if_fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// Generic pipeline register with hold and flush, used for IF/ID and reusable
// for later stage boundaries.
//   clk, rst_n : clock, asynchronous active-low reset (loads RST_VAL).
//   hold       : keep current contents.
//   flush      : load FLUSH_VAL (bubble); takes priority over hold.
//   d / q      : data in / registered data out.
module if_id_reg #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL   = '0,
  parameter logic [W-1:0] FLUSH_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_q <= RST_VAL;
    else if (flush) r_q <= FLUSH_VAL;  // wrong-path contents: a held value is void too
    else if (!hold) r_q <= d;
  end

  assign q = r_q;
endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage. Owns the PC, addresses the combinational
// instruction memory and captures {valid, PC+4, instruction} into IF/ID.
//   clk, rst_n    : clock, asynchronous active-low reset.
//   stall         : hold PC, IF/ID and the fetch counter.
//   redirect      : load redirect_pc into PC and flush IF/ID (beats stall).
//   redirect_pc   : redirect target, low two bits ignored.
//   imem          : instruction-memory bus (master side).
//   if_id_instr   : registered instruction (NOP_INSTR when a bubble).
//   if_id_pc4     : registered PC+4 of that instruction (0 when a bubble).
//   if_id_valid   : 1 = real instruction, 0 = bubble.
//   fetch_count   : instructions accepted into IF/ID, wraps at 2^CNT_W.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(RESET_PC_C),
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  if_fetch_stage_if.master    imem,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic [ADDR_W-1:0]   if_id_pc4,
  output logic                if_id_valid,
  output logic [CNT_W-1:0]    fetch_count
);
  localparam int IFID_W = 1 + ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  // Reset and flush both leave a bubble: invalid, pc4 = 0, NOP word.
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, {ADDR_W{1'b0}}, NOP_INSTR};

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_fetch_count;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_redirect_aligned;
  logic              w_advance;
  logic [IFID_W-1:0] w_ifid_d;
  logic [IFID_W-1:0] w_ifid_q;

  assign w_pc_plus4         = r_pc + ADDR_W'(PC_INC);  // wraps silently past the top
  assign w_redirect_aligned = redirect_pc & ALIGN_MASK;
  assign w_advance          = !redirect && !stall;

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_pc <= RESET_PC;
    else if (redirect)  r_pc <= w_redirect_aligned;
    else if (!stall)    r_pc <= w_pc_plus4;
  end

  assign imem.imem_addr = r_pc & ALIGN_MASK;

  // Fetched-instruction counter: counts only real instructions entering IF/ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_fetch_count <= '0;
    else if (w_advance) r_fetch_count <= r_fetch_count + CNT_W'(1);
  end

  assign fetch_count = r_fetch_count;

  // IF/ID boundary
  assign w_ifid_d = {1'b1, w_pc_plus4, imem.imem_rdata};

  if_id_reg #(
    .W         (IFID_W),
    .RST_VAL   (IFID_BUBBLE),
    .FLUSH_VAL (IFID_BUBBLE)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (stall),
    .flush (redirect),
    .d     (w_ifid_d),
    .q     (w_ifid_q)
  );

  assign if_id_valid = w_ifid_q[IFID_W-1];
  assign if_id_pc4   = w_ifid_q[IFID_W-2 -: ADDR_W];
  assign if_id_instr = w_ifid_q[INSTR_W-1:0];
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. The instruction memory is an 8-word
// combinational ROM decoded on address bits [4:2]; word k is
// 32'hC0DE_0000 + k*32'h101.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_stage_if #(.ADDR_W(32)) imem_bus ();

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h101;
  endfunction

  assign imem_bus.imem_rdata = word(int'(imem_bus.imem_addr[4:2]));

  // Observable state packed as {imem_addr, instr, pc4, valid, count}.
  logic [112:0] obs;
  assign obs = {imem_bus.imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count};

  function automatic logic [112:0] ex(input logic [31:0] a, input logic [31:0] i,
                                      input logic [31:0] p, input logic v,
                                      input logic [15:0] c);
    return {a, i, p, v, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [112:0] e;
    rst_n = 1'b0;
    step();
    step();
    e = ex(32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset: got %h want %h", obs, e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [112:0] e;
    for (int k = 1; k <= 3; k++) begin
      step();
      e = ex(32'(4 * k), word(k - 1), 32'(4 * k), 1'b1, 16'(k));
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL free_run[%0d]: got %h want %h", k, obs, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [112:0] e;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      e = ex(32'd12, word(2), 32'd12, 1'b1, 16'd3);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL stall[%0d]: got %h want %h", k, obs, e);
      end
    end
    stall = 1'b0;
    step();
    e = ex(32'd16, word(3), 32'd16, 1'b1, 16'd4);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL stall_release: got %h want %h", obs, e);
    end
  endtask

  task automatic test_redirect();
    logic [112:0] e;
    // Move PC to 8 first (one bubble, counter unchanged).
    redirect = 1'b1;
    redirect_pc = 32'h8;
    step();
    e = ex(32'h8, 32'h0, 32'h0, 1'b0, 16'd4);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL redirect_to_8: got %h want %h", obs, e);
    end
    redirect_pc = 32'h1C;
    step();
    e = ex(32'h1C, 32'h0, 32'h0, 1'b0, 16'd4);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL redirect_to_1c: got %h want %h", obs, e);
    end
    redirect = 1'b0;
    step();
    e = ex(32'h20, word(7), 32'h20, 1'b1, 16'd5);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL redirect_resume: got %h want %h", obs, e);
    end
  endtask

  task automatic test_redirect_stall();
    logic [112:0] e;
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h4;
    step();
    e = ex(32'h4, 32'h0, 32'h0, 1'b0, 16'd5);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL redirect_and_stall: got %h want %h", obs, e);
    end
    stall = 1'b0;
    redirect = 1'b0;
    step();
    e = ex(32'h8, word(1), 32'h8, 1'b1, 16'd6);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL redirect_and_stall_resume: got %h want %h", obs, e);
    end
  endtask

  task automatic test_unaligned_multi_redirect();
    logic [112:0] e;
    redirect = 1'b1;
    redirect_pc = 32'h13;
    step();
    e = ex(32'h10, 32'h0, 32'h0, 1'b0, 16'd6);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL unaligned_redirect: got %h want %h", obs, e);
    end
    redirect_pc = 32'h1A;
    step();
    e = ex(32'h18, 32'h0, 32'h0, 1'b0, 16'd6);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL held_redirect: got %h want %h", obs, e);
    end
    redirect = 1'b0;
    step();
    e = ex(32'h1C, word(6), 32'h1C, 1'b1, 16'd7);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL held_redirect_resume: got %h want %h", obs, e);
    end
  endtask

  task automatic test_pc_wrap();
    logic [112:0] e;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    e = ex(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 16'd7);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL wrap_setup: got %h want %h", obs, e);
    end
    redirect = 1'b0;
    step();
    e = ex(32'h0, word(7), 32'h0, 1'b1, 16'd8);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL pc_wrap: got %h want %h", obs, e);
    end
  endtask

  task automatic test_async_reset();
    logic [112:0] e;
    redirect = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    step();
    e = ex(32'h14, word(4), 32'h14, 1'b1, 16'd9);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL pre_async_reset: got %h want %h", obs, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    e = ex(32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL async_reset_immediate: got %h want %h", obs, e);
    end
    step();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL async_reset_held: got %h want %h", obs, e);
    end
    rst_n = 1'b1;
    step();
    e = ex(32'h4, word(0), 32'h4, 1'b1, 16'd1);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_restart: got %h want %h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_unaligned_multi_redirect();
    test_pc_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
